wb_seq_mul: RTL and testbench
=============================

WB_SEQ_MUL -- requirements
Module: wb_seq_mul

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base of the 32-byte register window.
REQ-002 SHALL have port wb_clk_i  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports wbs_cyc_i and wbs_stb_i, each input  1  Wishbone cycle and strobe.
REQ-005 SHALL have ports wbs_we_i  input  1  write enable; wbs_sel_i  input  4  byte lanes.
REQ-006 SHALL have ports wbs_adr_i  input  32  byte address; wbs_dat_i  input  32  write data.
REQ-007 SHALL have ports wbs_ack_o  output  1  acknowledge; wbs_dat_o  output  32  read data.
REQ-008 SHALL have port irq_o  output  1  completion interrupt, level.

Function
REQ-009 SHALL decode a hit as cyc&stb&(adr[31:5]==BASE_ADDR[31:5]); offset = adr[4:2].
REQ-010 SHALL pulse wbs_ack_o for exactly one cycle, in the cycle after a hit, and not again until stb drops (one wait state, no back-to-back double ack).
REQ-011 SHALL perform register writes and read side effects in the ack cycle; wbs_dat_o valid in the ack cycle, 0 otherwise.
REQ-012 SHALL map: 0x00 OP_A rw, 0x04 OP_B rw, 0x08 CTRL w / STATUS r, 0x0C RES_LO r, 0x10 RES_HI r; other offsets ack, read 0, writes ignored.
REQ-013 SHALL honour wbs_sel_i per byte on OP_A/OP_B; CTRL uses lane 0 only (ignored if sel[0]=0).
REQ-014 SHALL decode CTRL bits: [0] START (self-clearing), [1] SIGNED, [2] IRQ_EN; SIGNED and IRQ_EN stored on every CTRL write.
REQ-015 SHALL read STATUS as {28'b0, SIGNED_latched, IRQ_EN, DONE, BUSY} at bits [3:0].
REQ-016 SHALL on START with BUSY=0 latch OP_A, OP_B, SIGNED into the core, set BUSY=1, clear DONE.
REQ-017 SHALL ignore START while BUSY=1, including in the completion cycle; computation continues unaffected.
REQ-018 SHALL allow OP_A/OP_B writes while BUSY; they do not alter the running product.
REQ-019 SHALL use a fixed 32-iteration radix-2 shift-add; BUSY high exactly 32 cycles starting the cycle after the START ack; zero operands take full latency.
REQ-020 SHALL on the 32nd busy cycle load RES_HI:RES_LO with the 64-bit product, clear BUSY, set DONE, all in the same edge.
REQ-021 SHALL in signed mode multiply magnitudes and two's-complement-negate the 64-bit result when operand signs differ; -2^31 handled as magnitude 2^31.
REQ-022 SHALL clear DONE on a read of RES_HI or on an accepted START; RES_LO read has no side effect.
REQ-023 SHALL drive irq_o registered = DONE & IRQ_EN (one-cycle lag).
REQ-024 SHALL keep result registers unchanged until the next completion.

Reset
REQ-025 SHALL on wb_rst_i=1 at a clock edge clear OP_A, OP_B, RES_LO, RES_HI, SIGNED, IRQ_EN, BUSY, DONE, core state; wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
REQ-026 SHALL abort an in-flight multiply on reset with no result update; reset dominates any simultaneous bus access or completion.

Structure
REQ-027 SHALL place register offsets, CTRL/STATUS bit positions and MUL_ITERS=32 in shared package mul_pkg.
REQ-028 SHALL implement the datapath in one sub-module seq_mul_core (start, signed, a, b -> busy, done pulse, 64-bit product); Wishbone decode and registers stay in wb_seq_mul.

Verification
REQ-029 SHALL cover unsigned: A=0xFFFFFFFF, B=0xFFFFFFFF, START -> BUSY 32 cycles, RES_HI=0xFFFFFFFE, RES_LO=0x00000001, DONE=1.
REQ-030 SHALL cover signed: A=0xFFFFFFFD(-3), B=7 -> RES_HI=0xFFFFFFFF, RES_LO=0xFFFFFFEB; A=B=0x80000000 -> 0x40000000_00000000.
REQ-031 SHALL cover START while busy plus OP_A rewrite mid-run -> result equals original operands, single completion.
REQ-032 SHALL cover IRQ_EN=1: completion -> irq_o high 1 cycle after DONE; RES_HI read -> DONE=0, irq_o low next cycle.
REQ-033 SHALL cover wb_rst_i pulse at busy cycle 10 -> all registers 0, no DONE, no irq; following START with A=6, B=7 -> RES_LO=42.
REQ-034 SHALL cover bus: sel=4'b0010 write 0xAABBCCDD to OP_A=0 -> reads 0x0000CC00; read offset 0x14 -> ack once, data 0.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared register map, CTRL/STATUS bit positions and iteration count for the
// Wishbone sequential multiplier.
package mul_pkg;

  localparam int MUL_ITERS = 32;
  localparam int CNT_W     = $clog2(MUL_ITERS);

  localparam logic [2:0] OFF_OP_A   = 3'd0;
  localparam logic [2:0] OFF_OP_B   = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_RES_LO = 3'd3;
  localparam logic [2:0] OFF_RES_HI = 3'd4;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_SIGNED_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;
  localparam int STAT_IRQ_EN_BIT = 2;
  localparam int STAT_SIGNED_BIT = 3;

  typedef enum logic {
    CORE_IDLE = 1'b0,
    CORE_RUN  = 1'b1
  } core_state_e;

  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_mul_core.sv
// Radix-2 shift-add multiplier: fixed MUL_ITERS iterations, sign handled by
// multiplying magnitudes and negating the 64-bit result.
module seq_mul_core
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_mode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITERS - 1);

  core_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [63:0]      sum;
  logic [31:0]      a_mag, b_mag;

  // Two's-complement negate of 0x80000000 yields 0x80000000, i.e. 2^31 as unsigned.
  assign a_mag = (signed_mode & a[31]) ? (~a + 32'd1) : a;
  assign b_mag = (signed_mode & b[31]) ? (~b + 32'd1) : b;
  assign sum   = acc_q + (mplier_q[0] ? mcand_q : 64'd0);

  assign busy    = (state_q == CORE_RUN);
  assign done    = (state_q == CORE_RUN) && (cnt_q == LAST_CNT);
  assign product = neg_q ? (~sum + 64'd1) : sum;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    unique case (state_q)
      CORE_IDLE: begin
        if (start) begin
          state_d  = CORE_RUN;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {32'd0, a_mag};
          mplier_d = b_mag;
          neg_d    = signed_mode & (a[31] ^ b[31]);
        end
      end
      CORE_RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = CORE_IDLE;
      end
      default: state_d = CORE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CORE_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: rtl/wb_seq_mul.sv
// Wishbone slave wrapping seq_mul_core: operand/result registers, CTRL/STATUS,
// one-wait-state acknowledge and level completion interrupt.
module wb_seq_mul
  import mul_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  logic        hit;
  logic [2:0]  offset;
  logic        wr, rd, ctrl_wr, core_start;
  logic        core_busy, core_done;
  logic [63:0] core_product;
  logic [31:0] rdata;
  logic        unused_adr_bits;

  logic        ack_q, ack_d;
  logic        served_q, served_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic        signed_q, signed_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        irq_q, irq_d;

  assign unused_adr_bits = ^wbs_adr_i[1:0];
  assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign offset = wbs_adr_i[4:2];

  // Accesses take effect in the ack cycle while the master still holds the request.
  assign wr         = ack_q & wbs_we_i;
  assign rd         = ack_q & ~wbs_we_i;
  assign ctrl_wr    = wr & (offset == OFF_CTRL) & wbs_sel_i[0];
  assign core_start = ctrl_wr & wbs_dat_i[CTRL_START_BIT] & ~core_busy;

  seq_mul_core u_core (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .start       (core_start),
    .signed_mode (wbs_dat_i[CTRL_SIGNED_BIT]),
    .a           (op_a_q),
    .b           (op_b_q),
    .busy        (core_busy),
    .done        (core_done),
    .product     (core_product)
  );

  always_comb begin
    rdata = 32'd0;
    unique case (offset)
      OFF_OP_A:   rdata = op_a_q;
      OFF_OP_B:   rdata = op_b_q;
      OFF_CTRL:   rdata = {28'd0, signed_q, irq_en_q, done_q, core_busy};
      OFF_RES_LO: rdata = res_lo_q;
      OFF_RES_HI: rdata = res_hi_q;
      default:    rdata = 32'd0;
    endcase
  end

  assign wbs_dat_o = ack_q ? rdata : 32'd0;
  assign wbs_ack_o = ack_q;
  assign irq_o     = irq_q;

  always_comb begin
    // served_q blocks a second ack until the master drops the strobe.
    ack_d    = hit & ~ack_q & ~served_q;
    served_d = wbs_cyc_i & wbs_stb_i & (served_q | ack_q);
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    signed_d = signed_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    if (wr && offset == OFF_OP_A) op_a_d = apply_sel(op_a_q, wbs_dat_i, wbs_sel_i);
    if (wr && offset == OFF_OP_B) op_b_d = apply_sel(op_b_q, wbs_dat_i, wbs_sel_i);
    if (ctrl_wr) begin
      signed_d = wbs_dat_i[CTRL_SIGNED_BIT];
      irq_en_d = wbs_dat_i[CTRL_IRQ_EN_BIT];
    end
    if (core_start || (rd && offset == OFF_RES_HI)) done_d = 1'b0;
    if (core_done) begin
      res_lo_d = core_product[31:0];
      res_hi_d = core_product[63:32];
      done_d   = 1'b1;
    end
    irq_d = done_q & irq_en_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      served_q <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      signed_q <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      served_q <= served_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      signed_q <= signed_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_wb_seq_mul.sv
// Directed bench for wb_seq_mul: bus decode, unsigned/signed products,
// busy behaviour, interrupt timing and reset abort.
module tb_wb_seq_mul;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_OPA = BASE + 32'h00;
  localparam logic [31:0] A_OPB = BASE + 32'h04;
  localparam logic [31:0] A_CTL = BASE + 32'h08;
  localparam logic [31:0] A_RLO = BASE + 32'h0C;
  localparam logic [31:0] A_RHI = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat_o;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int busy_cycles = 0;
  int done_pulses = 0;

  wb_seq_mul #(.BASE_ADDR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat_o),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.core_busy) busy_cycles <= busy_cycles + 1;
    if (dut.core_done) done_pulses <= done_pulses + 1;
  end

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r);
    int n;
    r = 32'h0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    n = 0;
    while (!ack && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (!ack) begin
      bad++;
      $display("FAIL bus_ack adr=%h got no ack, expected ack", a);
    end else r = rdat_o;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(a, 1'b1, d, 4'hF, dummy);
  endtask

  task automatic rd32(input logic [31:0] a, output logic [31:0] r);
    bus(a, 1'b0, 32'h0, 4'hF, r);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (dut.core_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (dut.core_busy) begin
      bad++;
      $display("FAIL busy_timeout still busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    total++;
    if ({ack, rdat_o, irq} !== 34'h0) begin
      bad++;
      $display("FAIL reset_outputs got ack=%b dat=%h irq=%b, expected 0/0/0", ack, rdat_o, irq);
    end
    rd32(A_OPA, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_opa got %h expected 0", r); end
    rd32(A_CTL, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_status got %h expected 0", r); end
    rd32(A_RHI, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_reshi got %h expected 0", r); end
  endtask

  task automatic test_unsigned();
    logic [31:0] r;
    int b0;
    wr32(A_OPA, 32'hFFFF_FFFF);
    wr32(A_OPB, 32'hFFFF_FFFF);
    b0 = busy_cycles;
    wr32(A_CTL, 32'h1);
    wait_idle();
    @(posedge clk); #1;
    total++;
    if (busy_cycles - b0 !== 32) begin
      bad++; $display("FAIL uns_latency got %0d expected 32", busy_cycles - b0);
    end
    rd32(A_CTL, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL uns_status got %h expected 2", r); end
    rd32(A_RLO, r);
    total++; if (r !== 32'h1) begin bad++; $display("FAIL uns_reslo got %h expected 1", r); end
    rd32(A_CTL, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL uns_lo_noside got %h expected 2", r); end
    rd32(A_RHI, r);
    total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL uns_reshi got %h expected fffffffe", r); end
    rd32(A_CTL, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL uns_done_clr got %h expected 0", r); end
    // zero operand still takes the full iteration count
    wr32(A_OPA, 32'h0);
    wr32(A_OPB, 32'h5);
    b0 = busy_cycles;
    wr32(A_CTL, 32'h1);
    wait_idle();
    @(posedge clk); #1;
    total++;
    if (busy_cycles - b0 !== 32) begin
      bad++; $display("FAIL zero_latency got %0d expected 32", busy_cycles - b0);
    end
    rd32(A_RHI, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL zero_reshi got %h expected 0", r); end
  endtask

  task automatic test_signed();
    logic [31:0] r;
    wr32(A_OPA, 32'hFFFF_FFFD);
    wr32(A_OPB, 32'h0000_0007);
    wr32(A_CTL, 32'h3);
    wait_idle();
    rd32(A_CTL, r);
    total++; if (r !== 32'hA) begin bad++; $display("FAIL sgn_status got %h expected a", r); end
    rd32(A_RLO, r);
    total++; if (r !== 32'hFFFF_FFEB) begin bad++; $display("FAIL sgn_reslo got %h expected ffffffeb", r); end
    rd32(A_RHI, r);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sgn_reshi got %h expected ffffffff", r); end
    wr32(A_OPA, 32'h8000_0000);
    wr32(A_OPB, 32'h8000_0000);
    wr32(A_CTL, 32'h3);
    wait_idle();
    rd32(A_RLO, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL min_reslo got %h expected 0", r); end
    rd32(A_RHI, r);
    total++; if (r !== 32'h4000_0000) begin bad++; $display("FAIL min_reshi got %h expected 40000000", r); end
    wr32(A_OPB, 32'h0000_0001);
    wr32(A_CTL, 32'h3);
    wait_idle();
    rd32(A_RLO, r);
    total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL minx1_reslo got %h expected 80000000", r); end
    rd32(A_RHI, r);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL minx1_reshi got %h expected ffffffff", r); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] r;
    int b0, d0;
    wr32(A_OPA, 32'd1000);
    wr32(A_OPB, 32'd3000);
    b0 = busy_cycles;
    d0 = done_pulses;
    wr32(A_CTL, 32'h1);
    wr32(A_OPA, 32'd7);
    wr32(A_CTL, 32'h1);
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (busy_cycles - b0 !== 32 || done_pulses - d0 !== 1) begin
      bad++;
      $display("FAIL swb_runs got busy=%0d done=%0d expected 32/1", busy_cycles - b0, done_pulses - d0);
    end
    rd32(A_RLO, r);
    total++; if (r !== 32'h002D_C6C0) begin bad++; $display("FAIL swb_reslo got %h expected 002dc6c0", r); end
    rd32(A_OPA, r);
    total++; if (r !== 32'd7) begin bad++; $display("FAIL swb_opa got %h expected 7", r); end
  endtask

  task automatic test_irq();
    logic [31:0] r;
    wr32(A_OPA, 32'd3);
    wr32(A_OPB, 32'd5);
    wr32(A_CTL, 32'h5);
    wait_idle();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_lag got %b expected 0", irq); end
    @(posedge clk); #1;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got %b expected 1", irq); end
    rd32(A_RHI, r);
    @(posedge clk); #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clr got %b expected 0", irq); end
    rd32(A_CTL, r);
    total++; if (r !== 32'h4) begin bad++; $display("FAIL irq_status got %h expected 4", r); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    int d0;
    wr32(A_OPA, 32'd11);
    wr32(A_OPB, 32'd13);
    d0 = done_pulses;
    wr32(A_CTL, 32'h5);
    repeat (9) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    total++;
    if ({ack, rdat_o, irq, dut.core_busy} !== 35'h0) begin
      bad++;
      $display("FAIL rst_abort_out got ack=%b dat=%h irq=%b busy=%b expected all 0", ack, rdat_o, irq, dut.core_busy);
    end
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (done_pulses - d0 !== 0 || irq !== 1'b0) begin
      bad++; $display("FAIL rst_no_done got done=%0d irq=%b expected 0/0", done_pulses - d0, irq);
    end
    rd32(A_CTL, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_status got %h expected 0", r); end
    rd32(A_OPB, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_opb got %h expected 0", r); end
    rd32(A_RLO, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_reslo got %h expected 0", r); end
    wr32(A_OPA, 32'd6);
    wr32(A_OPB, 32'd7);
    wr32(A_CTL, 32'h1);
    wait_idle();
    rd32(A_RLO, r);
    total++; if (r !== 32'd42) begin bad++; $display("FAIL rst_after_reslo got %0d expected 42", r); end
  endtask

  task automatic test_bus();
    logic [31:0] r;
    int acks, n;
    logic [31:0] ack_dat;
    wr32(A_OPA, 32'h0);
    bus(A_OPA, 1'b1, 32'hAABB_CCDD, 4'b0010, r);
    rd32(A_OPA, r);
    total++; if (r !== 32'h0000_CC00) begin bad++; $display("FAIL sel_opa got %h expected 0000cc00", r); end
    wr32(A_CTL, 32'h4);
    bus(A_CTL, 1'b1, 32'h0000_0003, 4'b1110, r);
    rd32(A_CTL, r);
    total++; if (r !== 32'h4) begin bad++; $display("FAIL ctrl_sel0 got %h expected 4", r); end
    // hold the strobe on an unmapped offset and count acknowledges
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h14; sel = 4'hF;
    acks = 0; ack_dat = 32'hDEAD_BEEF;
    for (n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (ack) begin acks++; ack_dat = rdat_o; end
    end
    cyc = 0; stb = 0;
    total++; if (acks !== 1) begin bad++; $display("FAIL unmapped_acks got %0d expected 1", acks); end
    total++; if (ack_dat !== 32'h0) begin bad++; $display("FAIL unmapped_dat got %h expected 0", ack_dat); end
    @(posedge clk); #1;
    cyc = 1; stb = 1; adr = BASE + 32'h20;
    acks = 0;
    for (n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 0; stb = 0;
    total++; if (acks !== 0) begin bad++; $display("FAIL miss_acks got %0d expected 0", acks); end
  endtask

  initial begin
    test_reset();
    test_bus();
    test_unsigned();
    test_signed();
    test_start_while_busy();
    test_irq();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
